dmem_arbiter: RTL

//   Shares the single-port data RAM (dmemory32) between the CPU load/store port and a DMA

---
 rtl/dmem_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store port and a DMA requester.
// The CPU has priority; a starvation counter forces a DMA grant after STARVE_MAX losses.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       rd_cpu_q, rd_dma_q;
  logic       dma_win;

  // DMA overrides the CPU only when both contend and DMA has waited long enough.
  assign dma_win   = cpu_req & dma_req & (starve_q == StarveMax);
  assign cpu_gnt   = rst & cpu_req & ~dma_win;
  assign dma_gnt   = rst & dma_req & (~cpu_req | dma_win);
  assign cpu_stall = rst & cpu_req & ~cpu_gnt;
  assign mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!dma_req || dma_gnt) begin
      starve_d = '0;
    end else if (cpu_gnt && (starve_q < StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      rd_cpu_q <= 1'b0;
      rd_dma_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_cpu_q <= cpu_gnt & ~cpu_we;
      rd_dma_q <= dma_gnt & ~dma_we;
    end
  end

  // The RAM returns data one cycle after the address; only the matching rvalid qualifies it.
  assign cpu_rvalid = rd_cpu_q;
  assign dma_rvalid = rd_dma_q;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule
